// File: rtl/axi_wrt_arbiter_if.sv
// rtl/axi_wrt_arbiter_if.sv - requester, write-buffer and AXI AW signals of the write-back arbiter
interface axi_wrt_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [LINE_W-1:0] line0;
    logic [LINE_W-1:0] line1;
    logic              done0;
    logic              done1;
    logic              busy;
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              w_buf_we;
    logic [LINE_W-1:0] w_line_mem;
    logic              wrt_AXI_finish;
    logic              wrt_reset;

    // Arbiter side: consumes requests, drives AW and the write buffer.
    modport master (
        input  req0, req1, addr0, addr1, line0, line1, awready, wrt_AXI_finish,
        output done0, done1, busy, awvalid, awaddr, awlen, awsize, awburst,
               w_buf_we, w_line_mem, wrt_reset
    );

    // Environment side: requesters, AXI slave and write buffer.
    modport slave (
        output req0, req1, addr0, addr1, line0, line1, awready, wrt_AXI_finish,
        input  done0, done1, busy, awvalid, awaddr, awlen, awsize, awburst,
               w_buf_we, w_line_mem, wrt_reset
    );
endinterface

// File: rtl/axi_wrt_arbiter.sv
// rtl/axi_wrt_arbiter.sv - two-port round-robin write-back scheduler in front of the AXI write buffer
module axi_wrt_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512
) (
    input  logic              clk,
    input  logic              rstn,
    axi_wrt_arbiter_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic              win;
    logic [ADDR_W-1:0] addr_win;

    // Next-state logic: arbitrate in IDLE, then walk the fixed write-back sequence.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_last_d = rr_last_q;
        awaddr_d  = awaddr_q;
        // On a tie the port that did not win last time goes; a lone request always wins.
        win       = (bus.req0 && bus.req1) ? ~rr_last_q : bus.req1;
        addr_win  = win ? bus.addr1 : bus.addr0;
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_d     = win;
                    rr_last_d = win;
                    awaddr_d  = {addr_win[ADDR_W-1:6], 6'b0};
                    state_d   = S_LOAD;
                end
            end
            S_LOAD:  state_d = S_ADDR;
            S_ADDR:  if (bus.awready) state_d = S_WAIT;
            S_WAIT:  if (bus.wrt_AXI_finish) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; rr_last resets to 1 so port 0 takes the first contest.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            gnt_q     <= 1'b0;
            rr_last_q <= 1'b1;
            awaddr_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_last_q <= rr_last_d;
            awaddr_q  <= awaddr_d;
        end
    end

    // Outputs decode straight from registered state, so an async reset clears them at once.
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.w_buf_we   = (state_q == S_LOAD);
    assign bus.w_line_mem = (state_q == S_LOAD) ? (gnt_q ? bus.line1 : bus.line0) : '0;
    assign bus.awvalid    = (state_q == S_ADDR);
    assign bus.awaddr     = awaddr_q;
    assign bus.awlen      = 8'd15;
    assign bus.awsize     = 3'b010;
    assign bus.awburst    = 2'b01;
    assign bus.wrt_reset  = (state_q == S_DONE);
    assign bus.done0      = (state_q == S_DONE) && !gnt_q;
    assign bus.done1      = (state_q == S_DONE) &&  gnt_q;
endmodule

// File: tb/tb_axi_wrt_arbiter.sv
// tb/tb_axi_wrt_arbiter.sv - self-checking bench for axi_wrt_arbiter
module tb_axi_wrt_arbiter;
    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    axi_wrt_arbiter_if #(.ADDR_W(32), .LINE_W(512)) bus();

    axi_wrt_arbiter #(.ADDR_W(32), .LINE_W(512)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Manual or modelled AXI slave / write buffer.
    logic         auto_en = 1'b0;
    logic         awready_man = 1'b0;
    logic         finish_man = 1'b0;
    logic         awready_m = 1'b0;
    logic         finish_m = 1'b0;
    logic [1:0]   bstate = 2'd0;
    logic [3:0]   beat = 4'd0;
    logic         wvalid_m = 1'b0;
    logic [511:0] buf_line = '0;
    logic [31:0]  wdata_m;
    logic         wlast_m;

    assign bus.awready        = auto_en ? awready_m : awready_man;
    assign bus.wrt_AXI_finish = auto_en ? finish_m  : finish_man;
    assign wdata_m            = buf_line[{beat, 5'b0} +: 32];
    assign wlast_m            = wvalid_m && (beat == 4'd15);

    always @(posedge clk) awready_m <= 1'($urandom_range(0, 1));

    always @(posedge clk) begin
        if (!auto_en) begin
            bstate <= 2'd0; wvalid_m <= 1'b0; finish_m <= 1'b0; beat <= 4'd0;
        end else begin
            case (bstate)
                2'd0: if (bus.w_buf_we) begin buf_line <= bus.w_line_mem; bstate <= 2'd1; end
                2'd1: if (bus.awvalid && bus.awready) begin bstate <= 2'd2; beat <= 4'd0; wvalid_m <= 1'b1; end
                2'd2: begin
                    if (beat == 4'd15) begin wvalid_m <= 1'b0; finish_m <= 1'b1; bstate <= 2'd3; end
                    else beat <= beat + 4'd1;
                end
                default: if (bus.wrt_reset) begin finish_m <= 1'b0; bstate <= 2'd0; end
            endcase
        end
    end

    int           exp_port[$];
    logic [31:0]  exp_word[$];

    task automatic apply_reset();
        auto_en = 1'b0;
        rstn = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [511:0] pat;
        bus.addr0 = '0; bus.addr1 = '0; bus.line0 = '0; bus.line1 = '0;
        apply_reset();
        checks++;
        if ({bus.busy, bus.awvalid, bus.w_buf_we, bus.wrt_reset, bus.done0, bus.done1} !== 6'b0 ||
            bus.awaddr !== 32'h0 || bus.w_line_mem !== 512'h0) begin
            errors++; $display("FAIL reset_state: outputs busy/awv/we/rst/d0/d1=%b awaddr=%h want all 0",
                {bus.busy, bus.awvalid, bus.w_buf_we, bus.wrt_reset, bus.done0, bus.done1}, bus.awaddr);
        end
        checks++;
        if (bus.awlen !== 8'd15 || bus.awsize !== 3'b010 || bus.awburst !== 2'b01) begin
            errors++; $display("FAIL aw_constants: len=%0d size=%b burst=%b want 15 010 01", bus.awlen, bus.awsize, bus.awburst);
        end
        for (int i = 0; i < 16; i++) pat[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        bus.addr0 = 32'h2000_0013; bus.line0 = pat; bus.req0 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.awvalid !== 1'b1) begin errors++; $display("FAIL reset_pre_addr: awvalid=%b want 1", bus.awvalid); end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.awvalid, bus.w_buf_we, bus.wrt_reset, bus.done0, bus.done1} !== 6'b0 ||
            bus.awaddr !== 32'h0 || bus.w_line_mem !== 512'h0) begin
            errors++; $display("FAIL reset_mid_addr: outputs=%b awaddr=%h want all 0",
                {bus.busy, bus.awvalid, bus.w_buf_we, bus.wrt_reset, bus.done0, bus.done1}, bus.awaddr);
        end
        bus.req0 = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.awvalid !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL reset_release: awvalid=%b busy=%b want 0 0", bus.awvalid, bus.busy);
            end
        end
    endtask

    task automatic test_single();
        logic [511:0] pat;
        for (int i = 0; i < 16; i++) pat[i*32 +: 32] = 32'hA5A5_0000 + 32'(i) * 32'h0101;
        auto_en = 1'b0;
        bus.addr0 = 32'h1000_0047; bus.line0 = pat; bus.req0 = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.w_buf_we !== 1'b1 || bus.w_line_mem !== pat || bus.awvalid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL single_load: we=%b awvalid=%b busy=%b line_ok=%b want 1 0 1 1",
                bus.w_buf_we, bus.awvalid, bus.busy, bus.w_line_mem === pat);
        end
        @(negedge clk);
        checks++;
        if (bus.awvalid !== 1'b1 || bus.awaddr !== 32'h1000_0040 || bus.w_buf_we !== 1'b0 || bus.w_line_mem !== 512'h0) begin
            errors++; $display("FAIL single_addr: awvalid=%b awaddr=%h we=%b want 1 10000040 0", bus.awvalid, bus.awaddr, bus.w_buf_we);
        end
        @(negedge clk);
        checks++;
        if (bus.awvalid !== 1'b1) begin errors++; $display("FAIL single_hold_t3: awvalid=%b want 1", bus.awvalid); end
        @(negedge clk);
        checks++;
        if (bus.awvalid !== 1'b1) begin errors++; $display("FAIL single_hold_t4: awvalid=%b want 1", bus.awvalid); end
        awready_man = 1'b1;
        @(negedge clk);
        awready_man = 1'b0;
        checks++;
        if (bus.awvalid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL single_wait: awvalid=%b busy=%b want 0 1", bus.awvalid, bus.busy);
        end
        for (int k = 6; k <= 25; k++) begin
            @(negedge clk);
            checks++;
            if (bus.done0 !== 1'b0 || bus.wrt_reset !== 1'b0) begin
                errors++; $display("FAIL single_early_done: cycle T+%0d done0=%b wrt_reset=%b want 0 0", k, bus.done0, bus.wrt_reset);
            end
        end
        finish_man = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.done0 !== 1'b1 || bus.wrt_reset !== 1'b1 || bus.done1 !== 1'b0) begin
            errors++; $display("FAIL single_done: done0=%b wrt_reset=%b done1=%b want 1 1 0", bus.done0, bus.wrt_reset, bus.done1);
        end
        finish_man = 1'b0; bus.req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done0 !== 1'b0 || bus.busy !== 1'b0 || bus.wrt_reset !== 1'b0) begin
            errors++; $display("FAIL single_idle: done0=%b busy=%b wrt_reset=%b want 0 0 0", bus.done0, bus.busy, bus.wrt_reset);
        end
    endtask

    task automatic test_round_robin();
        int   got;
        int   seen;
        logic [31:0] want_addr;
        apply_reset();
        auto_en = 1'b1;
        bus.addr0 = 32'h3000_0005; bus.addr1 = 32'h4000_00BF;
        bus.line0 = {16{32'h1111_0000}}; bus.line1 = {16{32'h2222_0000}};
        exp_port.delete();
        exp_port.push_back(0); exp_port.push_back(1); exp_port.push_back(0); exp_port.push_back(1);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 600 && seen < 4; cyc++) begin
            @(negedge clk);
            if (bus.awvalid && exp_port.size() > 0) begin
                want_addr = (exp_port[0] == 0) ? 32'h3000_0000 : 32'h4000_0080;
                checks++;
                if (bus.awaddr !== want_addr) begin
                    errors++; $display("FAIL rr_awaddr: awaddr=%h want %h", bus.awaddr, want_addr);
                end
            end
            if (bus.done0 || bus.done1) begin
                got = bus.done1 ? 1 : 0;
                checks++;
                if ((bus.done0 && bus.done1) || exp_port.size() == 0 || got != exp_port[0]) begin
                    errors++; $display("FAIL rr_order: contest %0d served port %0d (d0=%b d1=%b) want %0d",
                        seen, got, bus.done0, bus.done1, exp_port.size() > 0 ? exp_port[0] : -1);
                end
                if (exp_port.size() > 0) void'(exp_port.pop_front());
                seen++;
            end
        end
        checks++;
        if (seen != 4) begin errors++; $display("FAIL rr_timeout: completions=%0d want 4", seen); end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_held_off();
        bit hs = 0;
        bit d0 = 0;
        bit d1 = 0;
        auto_en = 1'b1;
        bus.addr0 = 32'h5000_0100; bus.addr1 = 32'h6000_1234;
        bus.req0 = 1'b1;
        for (int cyc = 0; cyc < 100 && !hs; cyc++) begin
            @(negedge clk);
            if (bus.awvalid && bus.awready) hs = 1;
        end
        @(negedge clk);
        bus.req1 = 1'b1;
        for (int cyc = 0; cyc < 100 && !d0; cyc++) begin
            @(negedge clk);
            if (bus.done0) begin d0 = 1; bus.req0 = 1'b0; end
            else begin
                checks++;
                if (bus.w_buf_we !== 1'b0 || bus.awvalid !== 1'b0 || bus.done1 !== 1'b0) begin
                    errors++; $display("FAIL held_off_leak: we=%b awvalid=%b done1=%b want 0 0 0", bus.w_buf_we, bus.awvalid, bus.done1);
                end
            end
        end
        checks++;
        if (!hs || !d0) begin errors++; $display("FAIL held_off_port0: handshake=%0d done0=%0d want 1 1", hs, d0); end
        for (int cyc = 0; cyc < 200 && !d1; cyc++) begin
            @(negedge clk);
            if (bus.awvalid) begin
                checks++;
                if (bus.awaddr !== 32'h6000_1200) begin
                    errors++; $display("FAIL held_off_awaddr: awaddr=%h want 60001200", bus.awaddr);
                end
            end
            if (bus.done1) begin d1 = 1; bus.req1 = 1'b0; end
        end
        checks++;
        if (!d1) begin errors++; $display("FAIL held_off_port1: done1 never seen"); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_buffer_stream();
        logic [511:0] ln;
        logic [31:0]  w;
        int           port;
        int           idx;
        bit           dn;
        auto_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < 16; i++) begin
                ln[i*32 +: 32] = $urandom;
                exp_word.push_back(ln[i*32 +: 32]);
            end
            port = int'($urandom_range(0, 1));
            if (port == 0) begin bus.line0 = ln; bus.addr0 = $urandom; bus.req0 = 1'b1; end
            else           begin bus.line1 = ln; bus.addr1 = $urandom; bus.req1 = 1'b1; end
            idx = 0; dn = 0;
            for (int cyc = 0; cyc < 200 && !dn; cyc++) begin
                @(negedge clk);
                if (wvalid_m) begin
                    checks++;
                    if (exp_word.size() == 0) begin
                        errors++; $display("FAIL stream_extra_beat: line %0d beat %0d data=%h", n, idx, wdata_m);
                    end else begin
                        w = exp_word.pop_front();
                        if (wdata_m !== w || wlast_m !== (idx == 15)) begin
                            errors++; $display("FAIL stream_beat: line %0d beat %0d data=%h wlast=%b want %h %b",
                                n, idx, wdata_m, wlast_m, w, idx == 15);
                        end
                    end
                    idx++;
                end
                if ((port == 0 && bus.done0) || (port == 1 && bus.done1)) begin
                    dn = 1; bus.req0 = 1'b0; bus.req1 = 1'b0;
                end
            end
            @(negedge clk);
            checks++;
            if (!dn || idx != 16 || exp_word.size() != 0 || bstate !== 2'd0) begin
                errors++; $display("FAIL stream_line_end: line %0d done=%0d beats=%0d left=%0d buf_state=%0d want 1 16 0 0",
                    n, dn, idx, exp_word.size(), bstate);
                exp_word.delete();
            end
        end
    endtask

    task automatic test_spurious_finish();
        auto_en = 1'b0;
        repeat (2) @(negedge clk);
        finish_man = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.done0 !== 1'b0 || bus.done1 !== 1'b0 || bus.wrt_reset !== 1'b0) begin
                errors++; $display("FAIL spurious_idle: busy=%b d0=%b d1=%b rst=%b want 0 0 0 0", bus.busy, bus.done0, bus.done1, bus.wrt_reset);
            end
        end
        finish_man = 1'b0;
        bus.addr0 = 32'h7000_00FF; bus.req0 = 1'b1;
        repeat (2) @(negedge clk);
        finish_man = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.awvalid !== 1'b1 || bus.done0 !== 1'b0 || bus.wrt_reset !== 1'b0) begin
                errors++; $display("FAIL spurious_addr: awvalid=%b done0=%b rst=%b want 1 0 0", bus.awvalid, bus.done0, bus.wrt_reset);
            end
        end
        finish_man = 1'b0; awready_man = 1'b1;
        @(negedge clk);
        awready_man = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.awvalid !== 1'b0 || bus.busy !== 1'b1 || bus.done0 !== 1'b0) begin
            errors++; $display("FAIL spurious_wait: awvalid=%b busy=%b done0=%b want 0 1 0", bus.awvalid, bus.busy, bus.done0);
        end
        finish_man = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.done0 !== 1'b1 || bus.done1 !== 1'b0) begin
            errors++; $display("FAIL spurious_done: done0=%b done1=%b want 1 0", bus.done0, bus.done1);
        end
        finish_man = 1'b0; bus.req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL spurious_end: busy=%b want 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_held_off();
        test_buffer_stream();
        test_spurious_finish();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
